cpu_mem_arbiter: RTL and testbench

Shares one memory port between the multi-cycle CPU's instruction-fetch channel and its load/store channel. Each upstream channel sees its normal valid/ready handshakes. Downstream, the block allows one transaction in flight at a time, with round-robin arbitration when both channels request in the same cycle. Request fields and read data are registered, and per-channel grant counts are exported for the performance-counter bank.

---
 rtl/cpu_mem_arbiter_if.sv | 50 +++++
 rtl/cpu_mem_arbiter.sv | 117 +++++++++++
 tb/tb_cpu_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_if.sv
// rtl/cpu_mem_arbiter_if.sv - CPU fetch/load-store channels and shared memory port bundle
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   i_addr;
    logic                i_req_valid;
    logic                i_req_ready;
    logic [DATA_W-1:0]   i_rdata;
    logic                i_rvalid;
    logic                i_rready;

    logic [ADDR_W-1:0]   d_addr;
    logic                d_read;
    logic                d_write;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic                d_req_ready;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_rvalid;
    logic                d_rready;

    logic [ADDR_W-1:0]   m_addr;
    logic                m_read;
    logic                m_write;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_req_ready;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_rvalid;
    logic                m_rready;

    modport slave (
        input  i_addr, i_req_valid, i_rready,
        input  d_addr, d_read, d_write, d_wdata, d_wstrb, d_rready,
        input  m_req_ready, m_rdata, m_rvalid,
        output i_req_ready, i_rdata, i_rvalid,
        output d_req_ready, d_rdata, d_rvalid,
        output m_addr, m_read, m_write, m_wdata, m_wstrb, m_rready
    );

    modport master (
        output i_addr, i_req_valid, i_rready,
        output d_addr, d_read, d_write, d_wdata, d_wstrb, d_rready,
        output m_req_ready, m_rdata, m_rvalid,
        input  i_req_ready, i_rdata, i_rvalid,
        input  d_req_ready, d_rdata, d_rvalid,
        input  m_addr, m_read, m_write, m_wdata, m_wstrb, m_rready
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - round-robin single-outstanding arbiter between CPU fetch and load/store
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    cpu_mem_arbiter_if.slave bus,
    output logic [31:0] i_grant_cnt,
    output logic [31:0] d_grant_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_owner_d;
    logic                r_op_wr;
    logic                r_last_grant_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic [31:0]         r_i_cnt;
    logic [31:0]         r_d_cnt;

    logic                w_pend_i;
    logic                w_pend_d;
    logic                w_grant_i;
    logic                w_grant_d;

    assign w_pend_i = bus.i_req_valid;
    assign w_pend_d = bus.d_read | bus.d_write;

    always_comb begin
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // On a tie the channel that did not win last time goes first
                if (w_pend_i && w_pend_d) begin
                    w_grant_i = r_last_grant_d;
                    w_grant_d = !r_last_grant_d;
                end else begin
                    w_grant_i = w_pend_i;
                    w_grant_d = w_pend_d;
                end
                if (w_pend_i || w_pend_d)
                    w_next_state = S_REQ;
            end
            S_REQ: begin
                if (bus.m_req_ready)
                    w_next_state = r_op_wr ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.m_rvalid)
                    w_next_state = S_RSP;
            end
            S_RSP: begin
                if (r_owner_d ? bus.d_rready : bus.i_rready)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_owner_d      <= 1'b0;
            r_op_wr        <= 1'b0;
            r_last_grant_d <= 1'b1;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_rdata        <= '0;
            r_i_cnt        <= '0;
            r_d_cnt        <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_owner_d      <= 1'b0;
                r_last_grant_d <= 1'b0;
                r_op_wr        <= 1'b0;
                r_addr         <= bus.i_addr;
                r_wdata        <= '0;
                r_wstrb        <= '0;
                r_i_cnt        <= r_i_cnt + 32'd1;
            end else if (w_grant_d) begin
                r_owner_d      <= 1'b1;
                r_last_grant_d <= 1'b1;
                r_op_wr        <= bus.d_write;
                r_addr         <= bus.d_addr;
                r_wdata        <= bus.d_wdata;
                r_wstrb        <= bus.d_wstrb;
                r_d_cnt        <= r_d_cnt + 32'd1;
            end
            if (r_state == S_WAIT && bus.m_rvalid)
                r_rdata <= bus.m_rdata;
        end
    end

    assign bus.i_req_ready = w_grant_i;
    assign bus.d_req_ready = w_grant_d;
    assign bus.m_addr      = r_addr;
    assign bus.m_wdata     = r_wdata;
    assign bus.m_wstrb     = r_wstrb;
    assign bus.m_read      = (r_state == S_REQ) && !r_op_wr;
    assign bus.m_write     = (r_state == S_REQ) && r_op_wr;
    assign bus.m_rready    = (r_state == S_WAIT);
    assign bus.i_rvalid    = (r_state == S_RSP) && !r_owner_d;
    assign bus.d_rvalid    = (r_state == S_RSP) && r_owner_d;
    assign bus.i_rdata     = r_rdata;
    assign bus.d_rdata     = r_rdata;
    assign i_grant_cnt     = r_i_cnt;
    assign d_grant_cnt     = r_d_cnt;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] i_grant_cnt;
    logic [31:0] d_grant_cnt;
    int          n_tests;
    int          n_fail;

    cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_addr = '0; bus.i_req_valid = 1'b0; bus.i_rready = 1'b0;
        bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        bus.d_wdata = '0; bus.d_wstrb = '0; bus.d_rready = 1'b0;
        bus.m_req_ready = 1'b0; bus.m_rdata = '0; bus.m_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step(); step();
        n_tests++;
        if ({bus.i_req_ready, bus.d_req_ready, bus.i_rvalid, bus.d_rvalid, bus.m_read, bus.m_write, bus.m_rready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=0000000", {bus.i_req_ready, bus.d_req_ready, bus.i_rvalid, bus.d_rvalid, bus.m_read, bus.m_write, bus.m_rready});
        end
        n_tests++;
        if ({bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.i_rdata, bus.d_rdata, i_grant_cnt, d_grant_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data addr=%h wdata=%h icnt=%0d dcnt=%0d exp all 0", bus.m_addr, bus.m_wdata, i_grant_cnt, d_grant_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        bus.i_addr = 32'h100; bus.i_req_valid = 1'b1;
        settle();
        n_tests++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_accept got=%b exp=10", {bus.i_req_ready, bus.d_req_ready});
        end
        step();
        bus.i_req_valid = 1'b0; bus.i_addr = 32'hDEAD0000;
        settle();
        n_tests++;
        if ({bus.m_read, bus.m_write, bus.m_rready, bus.i_req_ready} !== 4'b1000 || bus.m_addr !== 32'h100) begin
            n_fail++; $display("FAIL fetch_req ctl=%b addr=%h exp ctl=1000 addr=100", {bus.m_read, bus.m_write, bus.m_rready, bus.i_req_ready}, bus.m_addr);
        end
        bus.m_req_ready = 1'b1;
        step();
        bus.m_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_tests++;
            if ({bus.m_read, bus.m_rready, bus.i_rvalid} !== 3'b010) begin
                n_fail++; $display("FAIL fetch_wait%0d got=%b exp=010", k, {bus.m_read, bus.m_rready, bus.i_rvalid});
            end
            step();
        end
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h00000013;
        step();
        bus.m_rvalid = 1'b0; bus.m_rdata = 32'hFFFFFFFF;
        settle();
        n_tests++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.m_rready} !== 3'b100 || bus.i_rdata !== 32'h13) begin
            n_fail++; $display("FAIL fetch_rsp v=%b data=%h exp v=100 data=00000013", {bus.i_rvalid, bus.d_rvalid, bus.m_rready}, bus.i_rdata);
        end
        bus.i_rready = 1'b1;
        step();
        bus.i_rready = 1'b0;
        settle();
        n_tests++;
        if (bus.i_rvalid !== 1'b0 || i_grant_cnt !== 32'd1 || d_grant_cnt !== 32'd0) begin
            n_fail++; $display("FAIL fetch_done rvalid=%b icnt=%0d dcnt=%0d exp 0/1/0", bus.i_rvalid, i_grant_cnt, d_grant_cnt);
        end
    endtask

    task automatic test_store();
        bus.d_write = 1'b1; bus.d_addr = 32'h204; bus.d_wdata = 32'hAABBCCDD; bus.d_wstrb = 4'h3;
        settle();
        n_tests++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL store_accept got=%b exp=01", {bus.i_req_ready, bus.d_req_ready});
        end
        step();
        bus.d_write = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            settle();
            n_tests++;
            if ({bus.m_write, bus.m_read, bus.d_rvalid} !== 3'b100 || bus.m_addr !== 32'h204 || bus.m_wdata !== 32'hAABBCCDD || bus.m_wstrb !== 4'h3) begin
                n_fail++; $display("FAIL store_hold%0d ctl=%b addr=%h wdata=%h wstrb=%h exp 100/204/aabbccdd/3", k, {bus.m_write, bus.m_read, bus.d_rvalid}, bus.m_addr, bus.m_wdata, bus.m_wstrb);
            end
            if (k == 3) bus.m_req_ready = 1'b1;
            step();
        end
        bus.m_req_ready = 1'b0;
        settle();
        n_tests++;
        if ({bus.m_write, bus.m_rready, bus.d_rvalid, bus.i_rvalid} !== 4'b0 || d_grant_cnt !== 32'd1) begin
            n_fail++; $display("FAIL store_done ctl=%b dcnt=%0d exp 0000/1", {bus.m_write, bus.m_rready, bus.d_rvalid, bus.i_rvalid}, d_grant_cnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_i;
        exp_i = 3'b101;
        for (int r = 0; r < 3; r++) begin
            bus.i_req_valid = 1'b1; bus.i_addr = 32'h1000 + r;
            bus.d_read = 1'b1; bus.d_addr = 32'h2000 + 4 * r;
            settle();
            n_tests++;
            if ({bus.i_req_ready, bus.d_req_ready} !== {exp_i[r], !exp_i[r]}) begin
                n_fail++; $display("FAIL rr_round%0d got=%b exp=%b", r, {bus.i_req_ready, bus.d_req_ready}, {exp_i[r], !exp_i[r]});
            end
            step();
            bus.i_req_valid = 1'b0; bus.d_read = 1'b0;
            bus.m_req_ready = 1'b1;
            step();
            bus.m_req_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hC0DE0000 + r;
            step();
            bus.m_rvalid = 1'b0;
            settle();
            n_tests++;
            if ({bus.i_rvalid, bus.d_rvalid} !== {exp_i[r], !exp_i[r]}) begin
                n_fail++; $display("FAIL rr_rsp%0d got=%b exp=%b", r, {bus.i_rvalid, bus.d_rvalid}, {exp_i[r], !exp_i[r]});
            end
            bus.i_rready = 1'b1; bus.d_rready = 1'b1;
            step();
            bus.i_rready = 1'b0; bus.d_rready = 1'b0;
        end
        n_tests++;
        if (i_grant_cnt !== 32'd3 || d_grant_cnt !== 32'd2) begin
            n_fail++; $display("FAIL rr_counts icnt=%0d dcnt=%0d exp 3/2", i_grant_cnt, d_grant_cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.i_req_valid = 1'b1; bus.i_addr = 32'h500;
        bus.d_read = 1'b1; bus.d_addr = 32'h300;
        settle();
        n_tests++;
        if ({bus.i_req_ready, bus.d_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_accept got=%b exp=01", {bus.i_req_ready, bus.d_req_ready});
        end
        step();
        bus.d_read = 1'b0;
        bus.m_req_ready = 1'b1;
        step();
        bus.m_req_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h12345678;
        step();
        bus.m_rvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0BADBEEF; end
            settle();
            n_tests++;
            if ({bus.d_rvalid, bus.i_rvalid, bus.i_req_ready} !== 3'b100 || bus.d_rdata !== 32'h12345678) begin
                n_fail++; $display("FAIL bp_hold%0d ctl=%b data=%h exp 100/12345678", k, {bus.d_rvalid, bus.i_rvalid, bus.i_req_ready}, bus.d_rdata);
            end
            step();
            bus.m_rvalid = 1'b0;
        end
        bus.i_req_valid = 1'b0; bus.d_rready = 1'b1;
        step();
        bus.d_rready = 1'b0;
        settle();
        n_tests++;
        if ({bus.d_rvalid, bus.m_read} !== 2'b00 || d_grant_cnt !== 32'd3 || i_grant_cnt !== 32'd3) begin
            n_fail++; $display("FAIL bp_done ctl=%b icnt=%0d dcnt=%0d exp 00/3/3", {bus.d_rvalid, bus.m_read}, i_grant_cnt, d_grant_cnt);
        end
    endtask

    task automatic test_read_write_both();
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h40C; bus.d_wdata = 32'h55AA55AA; bus.d_wstrb = 4'hF;
        step();
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        settle();
        n_tests++;
        if ({bus.m_write, bus.m_read} !== 2'b10 || bus.m_wdata !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL rw_op ctl=%b wdata=%h exp 10/55aa55aa", {bus.m_write, bus.m_read}, bus.m_wdata);
        end
        bus.m_req_ready = 1'b1;
        step();
        bus.m_req_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h11111111;
        step();
        bus.m_rvalid = 1'b0;
        settle();
        n_tests++;
        if ({bus.d_rvalid, bus.m_rready, bus.m_read, bus.m_write} !== 4'b0 || d_grant_cnt !== 32'd4) begin
            n_fail++; $display("FAIL rw_done ctl=%b dcnt=%0d exp 0000/4", {bus.d_rvalid, bus.m_rready, bus.m_read, bus.m_write}, d_grant_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        bus.i_req_valid = 1'b1; bus.i_addr = 32'h800;
        step();
        bus.i_req_valid = 1'b0; bus.m_req_ready = 1'b1;
        step();
        bus.m_req_ready = 1'b0;
        settle();
        n_tests++;
        if (bus.m_rready !== 1'b1) begin
            n_fail++; $display("FAIL rstw_wait m_rready=%b exp 1", bus.m_rready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        n_tests++;
        if ({bus.m_rready, bus.m_read, bus.i_rvalid} !== 3'b0 || i_grant_cnt !== 32'd0 || d_grant_cnt !== 32'd0 || bus.m_addr !== 32'd0) begin
            n_fail++; $display("FAIL rstw_idle ctl=%b icnt=%0d dcnt=%0d addr=%h exp 000/0/0/0", {bus.m_rready, bus.m_read, bus.i_rvalid}, i_grant_cnt, d_grant_cnt, bus.m_addr);
        end
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADDEAD;
        step();
        bus.m_rvalid = 1'b0;
        step();
        n_tests++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00 || bus.i_rdata !== 32'd0) begin
            n_fail++; $display("FAIL rstw_stray v=%b data=%h exp 00/0", {bus.i_rvalid, bus.d_rvalid}, bus.i_rdata);
        end
        bus.i_req_valid = 1'b1; bus.i_addr = 32'h40;
        settle();
        n_tests++;
        if (bus.i_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstw_accept i_req_ready=%b exp 1", bus.i_req_ready);
        end
        step();
        bus.i_req_valid = 1'b0; bus.m_req_ready = 1'b1;
        settle();
        n_tests++;
        if (bus.m_addr !== 32'h40 || bus.m_read !== 1'b1) begin
            n_fail++; $display("FAIL rstw_req addr=%h rd=%b exp 40/1", bus.m_addr, bus.m_read);
        end
        step();
        bus.m_req_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFEF00D;
        step();
        bus.m_rvalid = 1'b0;
        settle();
        n_tests++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hCAFEF00D || i_grant_cnt !== 32'd1) begin
            n_fail++; $display("FAIL rstw_rsp v=%b data=%h icnt=%0d exp 1/cafef00d/1", bus.i_rvalid, bus.i_rdata, i_grant_cnt);
        end
        bus.i_rready = 1'b1;
        step();
        bus.i_rready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_backpressure();
        test_read_write_both();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
